// File: rtl/idli_sqi_arb_m.sv
// Two-requester round-robin arbiter driving a single SQI (quad-SPI) memory port.
// One transaction: command byte, 16-bit address, optional read dummy cycles, 16-bit data.
package idli_sqi_arb_pkg;
   typedef logic [3:0] sqi_data_t;
endpackage

module idli_sqi_arb_m
   import idli_sqi_arb_pkg::*;
#(
   parameter logic [7:0] CMD_RD    = 8'h03,
   parameter logic [7:0] CMD_WR    = 8'h02,
   parameter int         DUMMY_CYC = 2
) (
   input  logic             i_arb_gck,
   input  logic             i_arb_rst_n,
   input  logic [1:0]       i_arb_req,
   input  logic [1:0]       i_arb_wr,
   input  logic [1:0][15:0] i_arb_addr,
   input  logic [1:0][15:0] i_arb_wdata,
   output logic [1:0]       o_arb_gnt,
   output logic [1:0]       o_arb_done,
   output logic [15:0]      o_arb_rdata,
   output logic             o_arb_cs,
   output logic             o_arb_sio_oe,
   output sqi_data_t        o_arb_sio,
   input  sqi_data_t        i_arb_sio
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, END} state_t;

   localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_CYC - 1);

   state_t      state, state_nx;
   logic [1:0]  cnt, cnt_nx;
   logic [1:0]  gnt_q;
   logic        last_q;
   logic        wr_q;
   logic        win;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic [15:0] rdata_q;
   logic [7:0]  cmd_byte;

   function automatic sqi_data_t nib_sel(input logic [15:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    return w[15:12];
         2'd1:    return w[11:8];
         2'd2:    return w[7:4];
         default: return w[3:0];
      endcase
   endfunction

   // On a tie the requester that did not win last time gets the bus
   always_comb begin
      if (i_arb_req == 2'b11) win = ~last_q;
      else                    win = i_arb_req[1];
   end

   assign cmd_byte = wr_q ? CMD_WR : CMD_RD;

   always_ff @(posedge i_arb_gck or negedge i_arb_rst_n) begin
      if (!i_arb_rst_n) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         wr_q    <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (state == IDLE && |i_arb_req) begin
            gnt_q  <= win ? 2'b10 : 2'b01;
            last_q <= win;
            wr_q   <= i_arb_wr[win];
         end else if (state == END) begin
            gnt_q <= 2'b00;
         end
         if (state == DATA && !wr_q) begin
            case (cnt)
               2'd0:    rdata_q[15:12] <= i_arb_sio;
               2'd1:    rdata_q[11:8]  <= i_arb_sio;
               2'd2:    rdata_q[7:4]   <= i_arb_sio;
               default: rdata_q[3:0]   <= i_arb_sio;
            endcase
         end
      end
   end

   // Winner's address and write data are captured once so requesters may change them freely
   always_ff @(posedge i_arb_gck) begin
      if (state == IDLE && |i_arb_req) begin
         addr_q  <= i_arb_addr[win];
         wdata_q <= i_arb_wdata[win];
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt + 2'd1;
      o_arb_cs     = 1'b1;
      o_arb_sio_oe = 1'b0;
      o_arb_sio    = 4'h0;
      unique case (state)
         IDLE: begin
            cnt_nx = 2'd0;
            if (|i_arb_req) state_nx = CMD;
         end
         CMD: begin
            o_arb_cs     = 1'b0;
            o_arb_sio_oe = 1'b1;
            o_arb_sio    = nib_sel({cmd_byte, 8'h00}, cnt);
            if (cnt == 2'd1) begin
               state_nx = ADDR;
               cnt_nx   = 2'd0;
            end
         end
         ADDR: begin
            o_arb_cs     = 1'b0;
            o_arb_sio_oe = 1'b1;
            o_arb_sio    = nib_sel(addr_q, cnt);
            if (cnt == 2'd3) begin
               cnt_nx   = 2'd0;
               state_nx = (wr_q || DUMMY_CYC == 0) ? DATA : DUMMY;
            end
         end
         DUMMY: begin
            o_arb_cs = 1'b0;
            if (cnt == DUMMY_LAST) begin
               state_nx = DATA;
               cnt_nx   = 2'd0;
            end
         end
         DATA: begin
            o_arb_cs     = 1'b0;
            o_arb_sio_oe = wr_q;
            o_arb_sio    = wr_q ? nib_sel(wdata_q, cnt) : 4'h0;
            if (cnt == 2'd3) begin
               state_nx = END;
               cnt_nx   = 2'd0;
            end
         end
         END: begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 2'd0;
         end
      endcase
   end

   assign o_arb_gnt   = gnt_q;
   assign o_arb_done  = (state == END) ? gnt_q : 2'b00;
   assign o_arb_rdata = rdata_q;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Directed bench for idli_sqi_arb_m: one instance with two dummy cycles, one with none.
module tb_idli_sqi_arb_m;
   import idli_sqi_arb_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req;
   logic [1:0]       wr;
   logic [1:0][15:0] addr;
   logic [1:0][15:0] wdata;
   sqi_data_t        sio_in;

   logic [1:0]  gnt_a, done_a, gnt_b, done_b;
   logic [15:0] rdata_a, rdata_b;
   logic        cs_a, oe_a, cs_b, oe_b;
   sqi_data_t   sio_a, sio_b;

   bit          dsel = 1'b0;
   logic        m_cs, m_oe;
   logic [1:0]  m_gnt, m_done;
   logic [15:0] m_rdata;
   sqi_data_t   m_sio;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   idli_sqi_arb_m #(.CMD_RD(8'h03), .CMD_WR(8'h02), .DUMMY_CYC(2)) dut_a (
      .i_arb_gck(clk), .i_arb_rst_n(rst_n), .i_arb_req(req), .i_arb_wr(wr),
      .i_arb_addr(addr), .i_arb_wdata(wdata), .o_arb_gnt(gnt_a), .o_arb_done(done_a),
      .o_arb_rdata(rdata_a), .o_arb_cs(cs_a), .o_arb_sio_oe(oe_a), .o_arb_sio(sio_a),
      .i_arb_sio(sio_in));

   idli_sqi_arb_m #(.CMD_RD(8'h03), .CMD_WR(8'h02), .DUMMY_CYC(0)) dut_b (
      .i_arb_gck(clk), .i_arb_rst_n(rst_n), .i_arb_req(req), .i_arb_wr(wr),
      .i_arb_addr(addr), .i_arb_wdata(wdata), .o_arb_gnt(gnt_b), .o_arb_done(done_b),
      .o_arb_rdata(rdata_b), .o_arb_cs(cs_b), .o_arb_sio_oe(oe_b), .o_arb_sio(sio_b),
      .i_arb_sio(sio_in));

   assign m_cs    = dsel ? cs_b    : cs_a;
   assign m_oe    = dsel ? oe_b    : oe_a;
   assign m_sio   = dsel ? sio_b   : sio_a;
   assign m_gnt   = dsel ? gnt_b   : gnt_a;
   assign m_done  = dsel ? done_b  : done_a;
   assign m_rdata = dsel ? rdata_b : rdata_a;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Waits for cs low, then records one transaction up to its END cycle, playing memory on reads.
   task automatic observe(input bit dsel_i, input int base, input logic [15:0] rnib,
                          input int drop_at, output int w, output int ncyc,
                          output logic [63:0] nibs, output logic [63:0] oepat,
                          output logic [1:0] g, output bit g_ok,
                          output logic [1:0] done_v, output logic [15:0] rd);
      int k;
      dsel  = dsel_i;
      w     = 0;
      nibs  = 64'h0;
      oepat = 64'h0;
      g_ok  = 1'b1;
      g     = 2'b00;
      do begin
         @(negedge clk);
         w++;
      end while (m_cs && w < 20);
      if (m_cs) chk("cs_start_timeout", 64'(m_cs), 64'h0);
      k = 0;
      g = m_gnt;
      while (!m_cs && k < 30) begin
         if (m_oe) nibs = {nibs[59:0], m_sio};
         oepat = oepat | (64'(m_oe) << k);
         if (m_gnt !== g) g_ok = 1'b0;
         if (k >= base && k < base + 4) sio_in = rnib[(15 - 4 * (k - base)) -: 4];
         else                           sio_in = 4'h0;
         if (k == drop_at) req = 2'b00;
         @(negedge clk);
         k++;
      end
      if (k >= 30) chk("cs_end_timeout", 64'(m_cs), 64'h1);
      ncyc   = k;
      done_v = m_done;
      rd     = m_rdata;
   endtask

   int          w, ncyc;
   logic [63:0] nibs, oepat;
   logic [1:0]  g, done_v;
   bit          g_ok;
   logic [15:0] rd;
   logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; req = 2'b00; wr = 2'b00; addr = '0; wdata = '0; sio_in = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_cs", 64'(cs_a), 64'h1);
      chk("rst_oe", 64'(oe_a), 64'h0);
      chk("rst_sio", 64'(sio_a), 64'h0);
      chk("rst_gnt", 64'(gnt_a), 64'h0);
      chk("rst_done", 64'(done_a), 64'h0);
      chk("rst_rdata", 64'(rdata_a), 64'h0);
      rst_n = 1'b1;

      // fetch read of 0x1234 returning ABCD
      req = 2'b01; wr = 2'b00; addr[0] = 16'h1234;
      observe(1'b0, 8, 16'hABCD, 0, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
      chk("rd_ncyc", 64'(ncyc), 64'd12);
      chk("rd_nibs", nibs, 64'h031234);
      chk("rd_oe", oepat, 64'h03F);
      chk("rd_gnt", 64'(g), 64'h1);
      chk("rd_gnt_hold", 64'(g_ok), 64'h1);
      chk("rd_done", 64'(done_v), 64'h1);
      chk("rd_rdata", 64'(rd), 64'hABCD);
      @(negedge clk);
      chk("rd_done_pulse", 64'(done_a), 64'h0);
      chk("rd_gnt_off", 64'(gnt_a), 64'h0);

      // load/store write of BEEF to 0x00F0; memory noise must not reach rdata
      req = 2'b10; wr = 2'b10; addr[1] = 16'h00F0; wdata[1] = 16'hBEEF;
      observe(1'b0, 6, 16'h9999, 0, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
      chk("wr_ncyc", 64'(ncyc), 64'd10);
      chk("wr_nibs", nibs, 64'h0200F0BEEF);
      chk("wr_oe", oepat, 64'h3FF);
      chk("wr_gnt", 64'(g), 64'h2);
      chk("wr_done", 64'(done_v), 64'h2);
      chk("wr_rdata", 64'(rd), 64'hABCD);

      // both requesting from reset: grants alternate with one idle cycle between
      rst_n = 1'b0; req = 2'b11; wr = 2'b00; addr[0] = 16'h1111; addr[1] = 16'h2222;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         observe(1'b0, 8, 16'h0000, -1, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
         chk($sformatf("rr_gnt%0d", i), 64'(g), 64'(exp_g[i]));
         chk($sformatf("rr_done%0d", i), 64'(done_v), 64'(exp_g[i]));
         if (i > 0) chk($sformatf("rr_gap%0d", i), 64'(w), 64'd2);
      end
      req = 2'b00;
      repeat (2) @(negedge clk);

      // request dropped during ADDR
      req = 2'b01; wr = 2'b01; addr[0] = 16'h0ACE; wdata[0] = 16'h1234;
      observe(1'b0, 6, 16'h0000, 3, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
      chk("drop_nibs", nibs, 64'h020ACE1234);
      chk("drop_done", 64'(done_v), 64'h1);
      repeat (3) @(negedge clk);
      chk("drop_idle_cs", 64'(cs_a), 64'h1);

      // reset mid-DATA of a fetch read, then a tie must go to fetch again
      req = 2'b01; wr = 2'b00; addr[0] = 16'h4321;
      dsel = 1'b0;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (cs_a && w < 20);
      chk("abort_start", 64'(cs_a), 64'h0);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      req = 2'b11;
      #1;
      chk("abort_cs", 64'(cs_a), 64'h1);
      chk("abort_gnt", 64'(gnt_a), 64'h0);
      chk("abort_oe", 64'(oe_a), 64'h0);
      chk("abort_done", 64'(done_a), 64'h0);
      @(negedge clk);
      chk("abort_done2", 64'(done_a), 64'h0);
      rst_n = 1'b1;
      observe(1'b0, 8, 16'h0F0F, 0, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
      chk("abort_next_gnt", 64'(g), 64'h1);
      chk("abort_next_nibs", nibs, 64'h034321);
      chk("abort_next_rdata", 64'(rd), 64'h0F0F);

      // no dummy cycles: read goes straight from address to data
      rst_n = 1'b0; req = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req = 2'b01; wr = 2'b00; addr[0] = 16'h5A5A;
      observe(1'b1, 6, 16'h1357, 0, w, ncyc, nibs, oepat, g, g_ok, done_v, rd);
      chk("d0_ncyc", 64'(ncyc), 64'd10);
      chk("d0_nibs", nibs, 64'h035A5A);
      chk("d0_oe", oepat, 64'h03F);
      chk("d0_done", 64'(done_v), 64'h1);
      chk("d0_rdata", 64'(rd), 64'h1357);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/idli_sqi_arb_m.md
IDLI_SQI_ARB_M -- requirements
Module: idli_sqi_arb_m

Interface
REQ-001 SHALL have parameter CMD_RD, default 8'h03, meaning the SQI read command byte.
REQ-002 SHALL have parameter CMD_WR, default 8'h02, meaning the SQI write command byte.
REQ-003 SHALL have parameter DUMMY_CYC, default 2, meaning the number of read dummy nibble cycles (range 0..3).
REQ-004 SHALL have port i_arb_gck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_arb_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_arb_req, input, 2 bits: per-requester request; index 0 is fetch, index 1 is load/store.
REQ-007 SHALL have port i_arb_wr, input, 2 bits: per-requester direction, 1 = write, 0 = read.
REQ-008 SHALL have port i_arb_addr, input, 2x16 bits: per-requester word address.
REQ-009 SHALL have port i_arb_wdata, input, 2x16 bits: per-requester write data.
REQ-010 SHALL have port o_arb_gnt, output, 2 bits: one-hot grant, held for the whole transaction.
REQ-011 SHALL have port o_arb_done, output, 2 bits: one-cycle completion pulse to the granted requester.
REQ-012 SHALL have port o_arb_rdata, output, 16 bits: read data, valid in the o_arb_done cycle.
REQ-013 SHALL have port o_arb_cs, output, 1 bit: SQI chip select, active-low.
REQ-014 SHALL have port o_arb_sio_oe, output, 1 bit: SIO output enable, 1 = drive.
REQ-015 SHALL have port o_arb_sio, output, sqi_data_t: nibble driven to memory.
REQ-016 SHALL have port i_arb_sio, input, sqi_data_t: nibble from memory.

Function
REQ-017 SHALL implement FSM states IDLE, CMD, ADDR, DUMMY, DATA, END; one nibble transferred per gck cycle in CMD/ADDR/DUMMY/DATA.
REQ-018 SHALL, in IDLE with any i_arb_req set, register a grant and enter CMD next cycle; o_arb_gnt asserts in that CMD cycle.
REQ-019 SHALL arbitrate round-robin: if both requests are set, grant the requester not granted last; the last-grant pointer resets to 1 so fetch wins the first tie.
REQ-020 SHALL latch addr, wr and wdata of the winner at grant; later requester input changes do not affect the transaction.
REQ-021 SHALL in CMD drive CMD_RD or CMD_WR for 2 cycles, MSB nibble first.
REQ-022 SHALL in ADDR drive the latched 16-bit address over 4 cycles, MSB nibble first.
REQ-023 SHALL for reads enter DUMMY for DUMMY_CYC cycles with o_arb_sio_oe=0, skipping DUMMY when DUMMY_CYC=0; writes go ADDR->DATA directly.
REQ-024 SHALL in DATA transfer 4 nibbles MSB first: writes drive wdata with oe=1; reads sample i_arb_sio into o_arb_rdata[15:12], [11:8], [7:4], [3:0] in successive cycles with oe=0.
REQ-025 SHALL hold o_arb_cs=0 in CMD through DATA and 1 in IDLE and END.
REQ-026 SHALL in END pulse o_arb_done for the granted index, deassert o_arb_gnt at the following edge, and return to IDLE.
REQ-027 SHALL make a write occupy 10 cs-low cycles and a read 10+DUMMY_CYC cs-low cycles; back-to-back requests start no sooner than one IDLE cycle after END.
REQ-028 SHALL ignore a deasserted request mid-transaction; the transaction completes and done still pulses.
REQ-029 SHALL hold o_arb_rdata stable between reads and never update it on writes.
REQ-030 SHALL drive o_arb_sio to 0 whenever o_arb_sio_oe=0.

Reset
REQ-031 SHALL on i_arb_rst_n low, asynchronously, force state IDLE, o_arb_cs=1, o_arb_sio_oe=0, o_arb_sio=0, o_arb_gnt=0, o_arb_done=0, o_arb_rdata=0, and the last-grant pointer=1.
REQ-032 SHALL abort an in-flight transaction on reset with no done pulse; cs rises immediately.

Verification
REQ-033 SHALL cover a single fetch read of addr 16'h1234 returning nibbles A,B,C,D -> SIO 0,3,1,2,3,4, two dummy cycles oe=0, rdata=16'hABCD, done[0] pulse, 12 cs-low cycles.
REQ-034 SHALL cover a load/store write of addr 16'h00F0 with wdata 16'hBEEF -> SIO 0,2,0,0,F,0,B,E,E,F with oe=1 throughout, done[1] pulse, rdata unchanged.
REQ-035 SHALL cover both requests set continuously from reset -> grants alternate 0,1,0,1 with one IDLE cycle between transactions.
REQ-036 SHALL cover a request dropped during ADDR -> the transaction finishes and done still pulses.
REQ-037 SHALL cover reset asserted mid-DATA -> cs=1, gnt=0, no done pulse; the next request starts at CMD with the fetch tie-priority restored.
REQ-038 SHALL cover DUMMY_CYC=0 -> a read goes ADDR->DATA with 10 cs-low cycles.
